// File: rtl/swc_sequencer.sv
// swc_sequencer: expands a preset+direction into Swc LD0/LD1/LD2/CCx, 4-cycle issue latency, cmd_ready only in IDLE.
// Define SWC_SEQUENCER_AUTORELOAD_EN to replay the latched command on every completion (periodic timer).
`ifndef Swc_NOP
`define Swc_NOP 4'h0
`endif
`ifndef Swc_LD0
`define Swc_LD0 4'h1
`endif
`ifndef Swc_LD1
`define Swc_LD1 4'h2
`endif
`ifndef Swc_LD2
`define Swc_LD2 4'h3
`endif
`ifndef Swc_CCU
`define Swc_CCU 4'h4
`endif
`ifndef Swc_CCD
`define Swc_CCD 4'h5
`endif

module swc_sequencer #(
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [23:0] cmd_value,
  input  logic        abort,
  output logic [11:0] swc_inst,
  output logic        swc_inst_en,
  input  logic [23:0] swc_counter,
  input  logic        swc_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_LD2, S_START, S_RUN, S_HALT, S_STOP, S_FAULT
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;
  localparam logic [11:0]          INST_NOP = {`Swc_NOP, 8'h00};

  state_t               state;
  logic [23:0]          value;
  logic                 dir;
  logic [TIMEOUT_W-1:0] wd;

  logic wd_expired;
  logic zero_seen;
  logic finish;

  assign wd_expired = (TIMEOUT != 0) && (state == S_RUN) && (wd == WD_LIMIT);
  // wd is cleared on RUN entry and saturates, so wd != 0 marks the second and later RUN cycles.
  assign zero_seen  = (state == S_RUN) && (wd != '0) && (swc_counter == 24'h0);
  assign finish     = zero_seen || ((state == S_START) && (value == 24'h0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      value       <= '0;
      dir         <= 1'b0;
      wd          <= '0;
      cmd_ready   <= 1'b1;
      swc_inst    <= INST_NOP;
      swc_inst_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      done        <= 1'b0;
      aborted     <= 1'b0;
      swc_inst    <= INST_NOP;
      swc_inst_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            value       <= cmd_value;
            dir         <= cmd_dir;
            state       <= S_LD0;
            swc_inst    <= {`Swc_LD0, cmd_value[7:0]};
            swc_inst_en <= 1'b1;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_LD0, S_LD1, S_LD2, S_START, S_RUN, S_HALT: begin
          // Priority: Swc error / watchdog, then abort, then completion.
          if (!swc_ready || wd_expired) begin
            state       <= S_STOP;
            swc_inst_en <= 1'b1;
          end else if (abort && (state != S_HALT)) begin
            state       <= S_HALT;
            swc_inst_en <= 1'b1;
            aborted     <= 1'b1;
          end else if (finish) begin
            done <= 1'b1;
`ifdef SWC_SEQUENCER_AUTORELOAD_EN
            state       <= S_LD0;
            swc_inst    <= {`Swc_LD0, value[7:0]};
            swc_inst_en <= 1'b1;
`else
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
`endif
          end else begin
            case (state)
              S_LD0: begin
                state       <= S_LD1;
                swc_inst    <= {`Swc_LD1, value[15:8]};
                swc_inst_en <= 1'b1;
              end
              S_LD1: begin
                state       <= S_LD2;
                swc_inst    <= {`Swc_LD2, value[23:16]};
                swc_inst_en <= 1'b1;
              end
              S_LD2: begin
                // A zero preset issues a NOP here so no count is ever started.
                state       <= S_START;
                swc_inst_en <= 1'b1;
                if (value != 24'h0) begin
                  swc_inst <= {(dir ? `Swc_CCD : `Swc_CCU), 8'h00};
                end
              end
              S_START: begin
                state <= S_RUN;
                wd    <= '0;
              end
              S_RUN: begin
                if (wd != WD_MAX) begin
                  wd <= wd + 1'b1;
                end
              end
              S_HALT: begin
                state     <= S_IDLE;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end
              default: state <= S_FAULT;
            endcase
          end
        end
        S_STOP: begin
          state <= S_FAULT;
          fault <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_swc_sequencer.sv
// Bench for swc_sequencer: behavioural Swc model plus an event-level reference of each command.
`ifndef Swc_NOP
`define Swc_NOP 4'h0
`endif
`ifndef Swc_LD0
`define Swc_LD0 4'h1
`endif
`ifndef Swc_LD1
`define Swc_LD1 4'h2
`endif
`ifndef Swc_LD2
`define Swc_LD2 4'h3
`endif
`ifndef Swc_CCU
`define Swc_CCU 4'h4
`endif
`ifndef Swc_CCD
`define Swc_CCD 4'h5
`endif

module tb_swc_sequencer;

  localparam int TO      = 8;
  localparam int K_DONE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_FAULT = 2;
  localparam logic [11:0] NOP_I = {`Swc_NOP, 8'h00};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [23:0] cmd_value = 24'h0;
  logic        abort = 1'b0;
  logic        swc_ready = 1'b1;
  logic [23:0] swc_counter;
  logic        cmd_ready, swc_inst_en, busy, done, aborted, fault;
  logic [11:0] swc_inst;

  int checks = 0;
  int errors = 0;

  swc_sequencer #(.TIMEOUT(TO), .TIMEOUT_W(24)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_value(cmd_value), .abort(abort), .swc_inst(swc_inst),
    .swc_inst_en(swc_inst_en), .swc_counter(swc_counter), .swc_ready(swc_ready),
    .busy(busy), .done(done), .aborted(aborted), .fault(fault)
  );

  always #5 clock = ~clock;

  // Swc model: instruction registered on one edge, executed on the next; counting stops at zero.
  logic [11:0] pend_inst;
  logic        pend_en;
  logic [1:0]  mode;  // 0 stopped, 1 up, 2 down

  function automatic logic [25:0] swc_step(input logic [23:0] cnt, input logic [1:0] md,
                                           input logic pen, input logic [11:0] pin);
    logic [23:0] n;
    logic [1:0]  m;
    n = cnt;
    m = md;
    if (m == 2'd1) begin
      n = n + 24'd1;
      if (n == 24'h0) m = 2'd0;
    end else if (m == 2'd2) begin
      n = n - 24'd1;
      if (n == 24'h0) m = 2'd0;
    end
    if (pen) begin
      case (pin[11:8])
        `Swc_LD0: n[7:0]   = pin[7:0];
        `Swc_LD1: n[15:8]  = pin[7:0];
        `Swc_LD2: n[23:16] = pin[7:0];
        `Swc_CCU: m = 2'd1;
        `Swc_CCD: m = 2'd2;
        default:  m = 2'd0;
      endcase
    end
    return {m, n};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      swc_counter <= 24'h0;
      mode        <= 2'd0;
      pend_inst   <= 12'h0;
      pend_en     <= 1'b0;
    end else begin
      {mode, swc_counter} <= swc_step(swc_counter, mode, pend_en, pend_inst);
      pend_inst <= swc_inst;
      pend_en   <= swc_inst_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flags packed as busy/ready/done/aborted/fault/inst_en.
  function automatic logic [31:0] obs_flags();
    return {26'd0, busy, cmd_ready, done, aborted, fault, swc_inst_en};
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({tag, " async flags b/r/d/a/f/en"}, obs_flags(), {26'd0, 6'b010000});
    chk({tag, " async inst"}, {20'd0, swc_inst}, {20'd0, NOP_I});
    cmd_valid = 1'b0;
    abort     = 1'b0;
    swc_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Reference: the command ends at cycle d (last LD/START/RUN cycle), with outcome k.
  task automatic run_cmd(input string name, input logic [23:0] v, input logic dr,
                         input int ab, input int rl, output int k);
    int d;
    int t;
    logic [11:0] ei;
    logic eb, er, ed, ea, ef, ee;
    if (v == 24'h0) begin
      d = 4;
      k = K_DONE;
    end else begin
      t = dr ? int'(v) : (1 << 24) - int'(v);
      // Zero visible in RUN cycle t+2 (cycle t+6), where the watchdog holds t+1.
      if (t + 1 < TO) begin
        d = t + 6;
        k = K_DONE;
      end else begin
        d = TO + 5;
        k = K_FAULT;
      end
    end
    if (rl >= 1 && rl <= d) begin
      d = rl;
      k = K_FAULT;
    end
    if (ab >= 1 && ab <= d && !(ab == d && k == K_FAULT)) begin
      d = ab;
      k = K_ABORT;
    end

    chk({name, " c0 ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_value = v;
    cmd_dir   = dr;
    cmd_valid = 1'b1;
    abort     = 1'b0;
    swc_ready = 1'b1;
    for (int c = 1; c <= d + 3; c++) begin
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_value = 24'($urandom);
      cmd_dir   = 1'($urandom);
      ee = 1'b0;
      ei = NOP_I;
      if (c <= d && c <= 3) begin
        ee = 1'b1;
        case (c)
          1:       ei = {`Swc_LD0, v[7:0]};
          2:       ei = {`Swc_LD1, v[15:8]};
          default: ei = {`Swc_LD2, v[23:16]};
        endcase
      end else if (c == 4 && c <= d) begin
        ee = 1'b1;
        ei = (v == 24'h0) ? NOP_I : {(dr ? `Swc_CCD : `Swc_CCU), 8'h00};
      end else if (c == d + 1 && k != K_DONE) begin
        ee = 1'b1;
      end
      ed = (c == d + 1) && (k == K_DONE);
      ea = (c == d + 1) && (k == K_ABORT);
      ef = (k == K_FAULT) && (c >= d + 2);
      eb = (c <= d) || ((c == d + 1) && (k != K_DONE));
      er = !eb && !ef;
      chk($sformatf("%s c%0d flags b/r/d/a/f/en", name, c), obs_flags(),
          {26'd0, eb, er, ed, ea, ef, ee});
      if (ee) chk($sformatf("%s c%0d inst", name, c), {20'd0, swc_inst}, {20'd0, ei});
      abort     = (c == ab);
      swc_ready = !(c == rl && rl <= d);
    end
    abort     = 1'b0;
    swc_ready = 1'b1;
  endtask

  initial begin
    int k;
    #1 reset = 1'b0;
    #1;
    chk("reset flags b/r/d/a/f/en", obs_flags(), {26'd0, 6'b010000});
    chk("reset inst", {20'd0, swc_inst}, {20'd0, NOP_I});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    abort = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("idle abort c%0d flags b/r/d/a/f/en", c), obs_flags(), {26'd0, 6'b010000});
    end
    abort = 1'b0;

`ifdef SWC_SEQUENCER_AUTORELOAD_EN
    cmd_value = 24'h000003;
    cmd_dir   = 1'b1;
    cmd_valid = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      int m;
      logic ee;
      logic [11:0] ei;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      m  = c % 9;
      ee = (c <= 21 && m >= 1 && m <= 4) || (c == 22);
      case (m)
        1:       ei = {`Swc_LD0, 8'h03};
        2:       ei = {`Swc_LD1, 8'h00};
        3:       ei = {`Swc_LD2, 8'h00};
        default: ei = {`Swc_CCD, 8'h00};
      endcase
      if (c == 22) ei = NOP_I;
      chk($sformatf("reload c%0d flags b/r/d/a/f/en", c), obs_flags(),
          {26'd0, (c <= 22), (c >= 23), (c == 10 || c == 19), (c == 22), 1'b0, ee});
      if (ee) chk($sformatf("reload c%0d inst", c), {20'd0, swc_inst}, {20'd0, ei});
      abort = (c == 21);
    end
    abort = 1'b0;
`else
    run_cmd("down6", 24'h000006, 1'b1, 0, 0, k);
    run_cmd("upFFFFFA", 24'hFFFFFA, 1'b0, 0, 0, k);
    run_cmd("abort40", 24'h000040, 1'b1, 8, 0, k);
    run_cmd("zero", 24'h000000, 1'b0, 0, 0, k);
    run_cmd("abort_vs_done", 24'h000002, 1'b1, 8, 0, k);
    run_cmd("abort_ld1", 24'h00A5C3, 1'b1, 2, 0, k);
    run_cmd("watchdog", 24'h000100, 1'b1, 0, 0, k);
    do_reset("wd reset");
    run_cmd("ready_ld1", 24'h123456, 1'b0, 0, 2, k);
    do_reset("rdy reset");

    cmd_value = 24'h000020;
    cmd_dir   = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("mid run busy", {31'd0, busy}, 32'd1);
    do_reset("mid reset");

    for (int i = 0; i < 40; i++) begin
      logic [23:0] v;
      logic dr;
      int ab, rl;
      case ($urandom_range(0, 3))
        0: begin v = 24'($urandom_range(0, 9)); dr = 1'b1; end
        1: begin v = 24'h0 - 24'($urandom_range(1, 9)); dr = 1'b0; end
        2: begin v = 24'($urandom); dr = 1'($urandom); end
        default: begin v = 24'($urandom_range(1, 6)); dr = 1'b1; end
      endcase
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0;
      rl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 14)) : 0;
      run_cmd($sformatf("rnd%0d", i), v, dr, ab, rl, k);
      if (k == K_FAULT) do_reset($sformatf("rnd%0d reset", i));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
